z_result_sequencer: RTL

//   Control sequencer for the 64-bit Z result register and its bus drive.
//   For each ALU operation it:
//     - launches the ALU and waits for completion (multi-cycle mul/div);
//     - pulses Zin to capture the result;
//     - drives Z low/high onto the bus with the matching destination enable (Rin, or LOin/HIin).

---
 rtl/z_result_sequencer_pkg.sv | 52 +++++
 rtl/z_result_sequencer_if.sv | 28 ++
 rtl/z_result_sequencer_cycle_watchdog.sv | 32 +++
 rtl/z_result_sequencer.sv | 93 +++++++++
 4 files changed

// File: rtl/z_result_sequencer_pkg.sv
// Shared types for the Z result sequencer: state encodings and the output-decode table.
package z_result_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LAUNCH   = 3'd1,
    S_WAIT_ALU = 3'd2,
    S_CAPTURE  = 3'd3,
    S_WB_LOW   = 3'd4,
    S_WB_HIGH  = 3'd5,
    S_DONE     = 3'd6,
    S_FAULT    = 3'd7
  } state_t;

  typedef struct packed {
    logic alu_start;
    logic zin;
    logic zlowout;
    logic zhighout;
    logic rin;
    logic loin;
    logic hiin;
    logic busy;
    logic done;
    logic fault;
  } ctl_t;

  // Moore decode; wide selects LO vs GPR as the destination of the low word
  function automatic ctl_t decode_ctl(input state_t st, input logic wide);
    ctl_t c;
    c      = ctl_t'(10'd0);
    c.busy = (st != S_IDLE);
    case (st)
      S_LAUNCH:  c.alu_start = 1'b1;
      S_CAPTURE: c.zin       = 1'b1;
      S_WB_LOW: begin
        c.zlowout = 1'b1;
        c.loin    = wide;
        c.rin     = !wide;
      end
      S_WB_HIGH: begin
        c.zhighout = 1'b1;
        c.hiin     = 1'b1;
      end
      S_DONE:    c.done  = 1'b1;
      S_FAULT:   c.fault = 1'b1;
      default:   c.done  = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/z_result_sequencer_if.sv
// Op-issue / ALU handshake and Z-path enable bundle between control unit and sequencer.
interface z_result_sequencer_if;
  logic Start;
  logic OpMulti;
  logic OpWide;
  logic Abort;
  logic ALU_Done;
  logic ALU_Start;
  logic Zin;
  logic Zlowout;
  logic Zhighout;
  logic Rin;
  logic LOin;
  logic HIin;
  logic Busy;
  logic Done;
  logic Fault;

  modport master (
    output Start, OpMulti, OpWide, Abort, ALU_Done,
    input  ALU_Start, Zin, Zlowout, Zhighout, Rin, LOin, HIin, Busy, Done, Fault
  );

  modport slave (
    input  Start, OpMulti, OpWide, Abort, ALU_Done,
    output ALU_Start, Zin, Zlowout, Zhighout, Rin, LOin, HIin, Busy, Done, Fault
  );
endinterface

// File: rtl/z_result_sequencer_cycle_watchdog.sv
// Saturating cycle counter that flags when LIMIT consecutive enabled cycles have elapsed.
module cycle_watchdog #(
  parameter int LIMIT = 64
) (
  input  logic Clock,
  input  logic Clear,
  input  logic Restart,
  input  logic Enable,
  output logic Expired
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count_r;

  // Count enabled cycles, holding at LAST so the counter never wraps
  always_ff @(posedge Clock) begin
    if (Clear) begin
      count_r <= '0;
    end else if (Restart) begin
      count_r <= '0;
    end else if (Enable && (count_r != LAST)) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign Expired = (count_r == LAST);

endmodule

// File: rtl/z_result_sequencer.sv
// Sequences ALU launch, Z capture and the low/high bus writeback for each issued op.
module z_result_sequencer
  import z_result_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                  Clock,
  input logic                  Clear,
  z_result_sequencer_if.slave  bus
);

  state_t state_r, state_s;
  logic   op_multi_r, op_multi_s;
  logic   op_wide_r, op_wide_s;
  ctl_t   ctl_r;
  logic   expired_s;

  // Counter is held at zero outside WAIT_ALU, so it reads zero on entry
  cycle_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .Clock   (Clock),
    .Clear   (Clear),
    .Restart (state_r != S_WAIT_ALU),
    .Enable  (state_r == S_WAIT_ALU),
    .Expired (expired_s)
  );

  // Next-state and op-latch logic; Abort overrides every transition
  always_comb begin
    state_s    = state_r;
    op_multi_s = op_multi_r;
    op_wide_s  = op_wide_r;
    if (bus.Abort) begin
      state_s    = S_IDLE;
      op_multi_s = 1'b0;
      op_wide_s  = 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.Start) begin
            state_s    = S_LAUNCH;
            op_multi_s = bus.OpMulti;
            op_wide_s  = bus.OpWide;
          end else begin
            state_s = S_IDLE;
          end
        end
        S_LAUNCH:   state_s = op_multi_r ? S_WAIT_ALU : S_CAPTURE;
        S_WAIT_ALU: begin
          if (bus.ALU_Done) begin
            state_s = S_CAPTURE;
          end else if (expired_s) begin
            state_s = S_FAULT;
          end else begin
            state_s = S_WAIT_ALU;
          end
        end
        S_CAPTURE:  state_s = S_WB_LOW;
        S_WB_LOW:   state_s = op_wide_r ? S_WB_HIGH : S_DONE;
        S_WB_HIGH:  state_s = S_DONE;
        S_DONE:     state_s = S_IDLE;
        S_FAULT:    state_s = S_FAULT;
        default:    state_s = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next-state decode, so they track state_r exactly
  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_r    <= S_IDLE;
      op_multi_r <= 1'b0;
      op_wide_r  <= 1'b0;
      ctl_r      <= ctl_t'(10'd0);
    end else begin
      state_r    <= state_s;
      op_multi_r <= op_multi_s;
      op_wide_r  <= op_wide_s;
      ctl_r      <= decode_ctl(state_s, op_wide_s);
    end
  end

  assign bus.ALU_Start = ctl_r.alu_start;
  assign bus.Zin       = ctl_r.zin;
  assign bus.Zlowout   = ctl_r.zlowout;
  assign bus.Zhighout  = ctl_r.zhighout;
  assign bus.Rin       = ctl_r.rin;
  assign bus.LOin      = ctl_r.loin;
  assign bus.HIin      = ctl_r.hiin;
  assign bus.Busy      = ctl_r.busy;
  assign bus.Done      = ctl_r.done;
  assign bus.Fault     = ctl_r.fault;

endmodule
